latency_meter: RTL

Measures display latency: starts a microsecond counter on the video generator's `starttrigger` pulse and stops it when the photo sensor sees the white test fields. Sits directly downstream of the video timing generator, beside the HDMI output path, and feeds the result/OSD logic. Reports one result per trigger, or a timeout flag.

---
 rtl/latency_pkg.sv | 17 +
 rtl/latency_meter_if.sv | 25 ++
 rtl/sensor_debounce.sv | 38 +++
 rtl/latency_meter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/latency_pkg.sv
// Shared types and constants for the display latency meter.
package latency_pkg;

  localparam int unsigned LATENCY_WIDTH = 20;
  localparam int unsigned AVG_SAMPLES   = 16;
  localparam int unsigned AVG_SHIFT     = 4;
  localparam int unsigned ACC_WIDTH     = 24;

  typedef enum logic [2:0] {
    StIdle,
    StMeasure,
    StDone,
    StAbort,
    StWaitDark
  } latency_state_t;

endpackage

// File: rtl/latency_meter_if.sv
// Trigger/sensor inputs and result outputs of the latency meter.
interface latency_meter_if;
  import latency_pkg::*;

  logic                     enable;
  logic                     starttrigger;
  logic                     sensor;
  logic [LATENCY_WIDTH-1:0] latency_us;
  logic                     latency_valid;
  logic                     timeout;
  logic                     busy;
  logic [LATENCY_WIDTH-1:0] avg_us;
  logic                     avg_valid;

  modport master (
    output enable, starttrigger, sensor,
    input  latency_us, latency_valid, timeout, busy, avg_us, avg_valid
  );

  modport slave (
    input  enable, starttrigger, sensor,
    output latency_us, latency_valid, timeout, busy, avg_us, avg_valid
  );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer for the raw photo sensor followed by a debounce counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor,
  output logic sensor_stable
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]      sync_q;
  logic            stable_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], sensor};
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sensor_stable = stable_q;

endmodule

// File: rtl/latency_meter.sv
// Display latency meter: counts microseconds from starttrigger until the debounced
// photo sensor sees light. Optional 16-sample averaging under LATENCY_AVERAGE_EN.
module latency_meter
  import latency_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_US   = 148,
  parameter int unsigned TIMEOUT_US      = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic            clock,
  input logic            reset,
  latency_meter_if.slave bus
);

  localparam int unsigned PsW = $clog2(CLOCKS_PER_US);

  latency_state_t           state_q;
  logic [PsW-1:0]           prescale_q;
  logic [LATENCY_WIDTH-1:0] us_count_q;
  logic [LATENCY_WIDTH-1:0] latency_q;
  logic                     latency_valid_q;
  logic                     timeout_q;
  logic                     sensor_stable;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock        (clock),
    .reset        (reset),
    .sensor       (bus.sensor),
    .sensor_stable(sensor_stable)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      prescale_q      <= '0;
      us_count_q      <= '0;
      latency_q       <= '0;
      latency_valid_q <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      latency_valid_q <= 1'b0;
      timeout_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A trigger with the screen already bright would measure nothing useful.
          if (bus.starttrigger && bus.enable && !sensor_stable) begin
            state_q    <= StMeasure;
            prescale_q <= '0;
            us_count_q <= '0;
          end
        end
        StMeasure: begin
          if (prescale_q == PsW'(CLOCKS_PER_US - 1)) begin
            prescale_q <= '0;
            us_count_q <= us_count_q + 1'b1;
          end else begin
            prescale_q <= prescale_q + 1'b1;
          end
          if (sensor_stable) begin
            state_q <= StDone;
          end else if (us_count_q == LATENCY_WIDTH'(TIMEOUT_US)) begin
            state_q <= StAbort;
          end
        end
        StDone: begin
          latency_q       <= us_count_q;
          latency_valid_q <= 1'b1;
          state_q         <= StWaitDark;
        end
        StAbort: begin
          timeout_q <= 1'b1;
          state_q   <= StWaitDark;
        end
        StWaitDark: begin
          if (!sensor_stable) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.latency_us    = latency_q;
  assign bus.latency_valid = latency_valid_q;
  assign bus.timeout       = timeout_q;
  assign bus.busy          = (state_q != StIdle);

`ifdef LATENCY_AVERAGE_EN
  localparam int unsigned NsW = $clog2(AVG_SAMPLES);

  logic [ACC_WIDTH-1:0]     acc_q;
  logic [ACC_WIDTH-1:0]     acc_sum;
  logic [NsW-1:0]           nsamp_q;
  logic [LATENCY_WIDTH-1:0] avg_q;
  logic                     avg_valid_q;

  assign acc_sum = acc_q + ACC_WIDTH'(us_count_q);

  // Sampled in StDone so avg_valid lines up with the 16th latency_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      nsamp_q     <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (state_q == StDone) begin
        if (nsamp_q == NsW'(AVG_SAMPLES - 1)) begin
          avg_q       <= LATENCY_WIDTH'(acc_sum >> AVG_SHIFT);
          avg_valid_q <= 1'b1;
          acc_q       <= '0;
          nsamp_q     <= '0;
        end else begin
          acc_q   <= acc_sum;
          nsamp_q <= nsamp_q + 1'b1;
        end
      end
    end
  end

  assign bus.avg_us    = avg_q;
  assign bus.avg_valid = avg_valid_q;
`else
  assign bus.avg_us    = '0;
  assign bus.avg_valid = 1'b0;
`endif

endmodule
